// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register and its entry flops.
// The skid buffer is selected with the PIPE_STAGE_SKID_EN macro.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CTRL_W_DEF = 5;
    localparam int unsigned TAG_W_DEF  = 5;

    // Bit positions inside the control bundle
    localparam int unsigned CTRL_REG_WRITE  = 4;
    localparam int unsigned CTRL_MEM_TO_REG = 3;
    localparam int unsigned CTRL_BRANCH     = 2;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 0;

    // Encoding equals the number of held entries
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload+valid holding register; clear kills valid and ctrl, data/tag hold.
module pipe_entry_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [TAG_W-1:0]  d_tag,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [TAG_W-1:0]  q_tag
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    // Clear wins over load so a killed slot always reads as a NOP
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (clr) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            ctrl_d  = d_ctrl;
            data_d  = d_data;
            tag_d   = d_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign q_valid = valid_q;
    assign q_ctrl  = ctrl_q;
    assign q_data  = data_q;
    assign q_tag   = tag_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush; PIPE_STAGE_SKID_EN adds a
// second (skid) entry for full throughput under back-pressure.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        occupancy
);

    state_e            state_q, state_d;
    logic              in_xfer, out_xfer;
    logic              load_main, clr_main;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;
    logic [TAG_W-1:0]  main_tag_d;

`ifdef PIPE_STAGE_SKID_EN
    logic              sel_skid, load_skid, clr_skid;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [TAG_W-1:0]  skid_tag;

    // Skid entry is valid exactly when the stage is FULL
    assign in_ready    = reset && !skid_valid;
    assign main_ctrl_d = sel_skid ? skid_ctrl : in_ctrl;
    assign main_data_d = sel_skid ? skid_data : in_data;
    assign main_tag_d  = sel_skid ? skid_tag  : in_tag;
`else
    assign in_ready    = reset && (out_ready || !out_valid);
    assign main_ctrl_d = in_ctrl;
    assign main_data_d = in_data;
    assign main_tag_d  = in_tag;
`endif

    assign in_xfer  = in_valid && in_ready && !flush;
    assign out_xfer = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Next state and entry load/clear controls; flush overrides everything
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        clr_main  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        sel_skid  = 1'b0;
        load_skid = 1'b0;
        clr_skid  = 1'b0;
`endif
        if (flush) begin
            state_d  = EMPTY;
            clr_main = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            clr_skid = 1'b1;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        load_main = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (out_xfer) begin
                        clr_main = 1'b1;
                        state_d  = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_xfer) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                FULL: begin
                    if (out_xfer) begin
                        load_main = 1'b1;
                        sel_skid  = 1'b1;
                        clr_skid  = 1'b1;
                        state_d   = ONE;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .TAG_W  (TAG_W)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (load_main),
        .clr     (clr_main),
        .d_ctrl  (main_ctrl_d),
        .d_data  (main_data_d),
        .d_tag   (main_tag_d),
        .q_valid (out_valid),
        .q_ctrl  (out_ctrl),
        .q_data  (out_data),
        .q_tag   (out_tag)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .TAG_W  (TAG_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (load_skid),
        .clr     (clr_skid),
        .d_ctrl  (in_ctrl),
        .d_data  (in_data),
        .d_tag   (in_tag),
        .q_valid (skid_valid),
        .q_ctrl  (skid_ctrl),
        .q_data  (skid_data),
        .q_tag   (skid_tag)
    );
`endif

    assign occupancy = 2'(state_q);

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of the datapath payload (ALU result, store data, addresses).
REQ-002 SHALL have parameter CTRL_W, default 5, meaning width of the control-bit bundle (regWrite, memToReg, branch, memRead, memWrite).
REQ-003 SHALL have parameter TAG_W, default 5, meaning width of the destination-register tag.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream stage holds a valid instruction.
REQ-007 in_ready  output  1  this stage accepts the instruction this cycle.
REQ-008 in_ctrl, in_data, in_tag  input  CTRL_W/DATA_W/TAG_W  upstream payload.
REQ-009 flush  input  1  kills every instruction held in the stage (branch mispredict).
REQ-010 out_valid  output  1  stage presents a valid instruction downstream.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_ctrl, out_data, out_tag  output  CTRL_W/DATA_W/TAG_W  registered payload.
REQ-013 occupancy  output  2  number of held entries, 0..2.

Function
REQ-014 A transfer SHALL occur on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-015 Latency SHALL be exactly 1 cycle from input transfer to out_valid when the stage is empty; the outputs SHALL be driven only from flops.
REQ-016 out_ctrl SHALL read all-zero whenever out_valid=0, so a bubble is always a NOP; out_data and out_tag SHALL hold their last value.
REQ-017 With the skid buffer enabled, the state machine SHALL have the states EMPTY, ONE (main entry valid), and FULL (main plus skid valid).
REQ-018 The state machine SHALL make these transitions: EMPTY->ONE on an input transfer; ONE->FULL on an input transfer without an output transfer; ONE->EMPTY on an output transfer without an input transfer; FULL->ONE on an output transfer. In FULL, in_ready=0.
REQ-019 The stage SHALL preserve order: the skid entry SHALL move to the main entry on the same edge that the main entry drains.
REQ-020 A simultaneous input and output transfer in ONE SHALL keep the state at ONE and load the new payload into the main entry.
REQ-021 flush SHALL take priority over every transfer: on the next edge, state=EMPTY, out_valid=0, out_ctrl=0, and any payload offered in the same cycle is discarded.
REQ-022 The in_ready value during a flush cycle SHALL be don't-care for upstream; the stage SHALL NOT capture data in that cycle.
REQ-023 Holding out_ready=0 SHALL keep out_* stable until the output transfer (stall).

Reset
REQ-024 reset low SHALL immediately clear the state to EMPTY and set out_valid=0, out_ctrl=0, out_data=0, out_tag=0, occupancy=0, and the skid entry to 0, independent of clk.
REQ-025 Reset asserted mid-transfer SHALL discard all held entries; the first accept after deassertion SHALL occur on the first rising edge with reset high.
REQ-026 in_ready SHALL be 0 while reset is low.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN defined SHALL give the 2-entry skid buffer, with in_ready registered (in_ready = state!=FULL) and full throughput under back-pressure.
REQ-028 Macro PIPE_STAGE_SKID_EN undefined SHALL give a single entry, with states EMPTY/ONE only, in_ready = out_ready || !out_valid (combinational), and occupancy never exceeding 1. All other requirements SHALL apply unchanged.

Structure
REQ-029 Package pipe_pkg SHALL hold the state enum (EMPTY, ONE, FULL), the default width constants, and the ctrl-bundle bit-index constants.
REQ-030 The stage SHALL use one sub-module, pipe_entry_reg: a single payload+valid flop with load, clear, and async reset, instantiated twice (main and skid).

Verification
REQ-031 The bench SHALL cover reset release: reset low with in_valid=1 and in_data=0xDEADBEEF -> out_valid=0, out_ctrl=0, out_data=0, in_ready=0; first rising edge after release with in_valid=1 and in_data=0xDEADBEEF -> out_data=0xDEADBEEF one cycle later.
REQ-032 The bench SHALL cover streaming: in_data=1,2,3,4 back-to-back with out_ready=1 -> out_data=1,2,3,4 on consecutive cycles, and occupancy stays at 1.
REQ-033 The bench SHALL cover the stall: out_ready=0 while sending 0xA then 0xB -> occupancy=2 and in_ready=0; then out_ready=1 -> 0xA then 0xB with no loss (skid enabled).
REQ-034 The bench SHALL cover the flush: in FULL, pulse flush together with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0xC never appears.
REQ-035 The bench SHALL cover the simultaneous transfer: in ONE with out_ready=1 and in_valid=1 (in_ctrl=5'b10011) -> occupancy stays 1, out_ctrl=5'b10011 next cycle.
REQ-036 The bench SHALL cover the no-skid build: PIPE_STAGE_SKID_EN undefined, out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle.
